// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and helpers for the ALU result path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    // Largest positive value of an n-bit two's complement number.
    function automatic logic [31:0] sat_max(input int unsigned n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

    // Bit pattern of the most negative n-bit two's complement number.
    function automatic logic [31:0] sat_min(input int unsigned n);
        return 32'd1 << (n - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buffer_2.sv
// ============================================================================
// Module      : skid_buffer_2
// Description : Two-entry valid/ready skid buffer with fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer_2
    import alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    buf_state_t       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_acc;
    logic             w_emit;

    assign w_acc     = in_valid & r_in_ready;
    assign w_emit    = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Handshake flags are registered with the state so neither port has a
    // combinational path from the opposite side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main      <= in_data;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_emit) begin
                        r_skid     <= in_data;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_emit && !w_acc) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_acc && w_emit) begin
                        r_main <= in_data;
                    end
                end
                ST_TWO: begin
                    if (w_emit) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_result_stage.sv
// ============================================================================
// Module      : add_result_stage
// Description : Overflow detect, saturate/wrap and skid-buffered output of the
//               signed adder sum, with sticky overflow flag and event counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_result_stage
    import alu_pkg::*;
#(
    parameter int N      = 4,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N:0]       in_result,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    input  logic             clr,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             w_ovf;
    logic [N-1:0]     w_conv;
    logic             w_in_ready;
    logic             w_acc;
    logic [N:0]       w_buf_out;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    // The N+1 bit sum fits in N bits only when its top two bits agree.
    assign w_ovf = in_result[N] ^ in_result[N-1];

    generate
        if (SAT_EN != 0) begin : g_sat
            localparam logic [N-1:0] c_max = N'(sat_max(N));
            localparam logic [N-1:0] c_min = N'(sat_min(N));
            assign w_conv = !w_ovf       ? in_result[N-1:0] :
                            in_result[N] ? c_min : c_max;
        end else begin : g_wrap
            assign w_conv = in_result[N-1:0];
        end
    endgenerate

    skid_buffer_2 #(
        .WIDTH (N + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   ({w_conv, w_ovf}),
        .in_ready  (w_in_ready),
        .out_valid (out_valid),
        .out_data  (w_buf_out),
        .out_ready (out_ready)
    );

    assign w_acc      = in_valid & w_in_ready;
    assign in_ready   = w_in_ready;
    assign out_data   = w_buf_out[N:1];
    assign out_ovf    = w_buf_out[0];
    assign ovf_sticky = r_sticky;
    assign ovf_count  = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (clr) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_acc && w_ovf) begin
            r_sticky <= 1'b1;
            if (r_count != c_cnt_max) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
